// File: rtl/regfile_msg_server_if.sv
// Command/response bus for regfile_msg_server.
// m_in_*  : command channel (op, addr, data) with sync (master valid) / notify (server ready).
// m_out_* : read-response channel (data) with notify (server valid) / sync (consumer ready).
// A transfer happens on a rising edge where sync and notify of the same channel are both 1.
interface regfile_msg_server_if #(
  parameter int unsigned NUM_REGS = 2,
  parameter int unsigned DATA_W   = 32
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [1:0]        m_in_op;
  logic [ADDR_W-1:0] m_in_addr;
  logic [DATA_W-1:0] m_in_data;
  logic              m_in_sync;
  logic              m_in_notify;
  logic [DATA_W-1:0] m_out_data;
  logic              m_out_sync;
  logic              m_out_notify;

  modport master (
    output m_in_op, m_in_addr, m_in_data, m_in_sync, m_out_sync,
    input  m_in_notify, m_out_data, m_out_notify
  );

  modport slave (
    input  m_in_op, m_in_addr, m_in_data, m_in_sync, m_out_sync,
    output m_in_notify, m_out_data, m_out_notify
  );
endinterface

// File: rtl/regfile_msg_server.sv
// Parametrised register-file server with blocking sync/notify message ports.
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - slave side of regfile_msg_server_if (command channel in, read response out)
// Commands: 00 WRITE, 01 READ, 10 ADD (wraps modulo 2^DATA_W), 11 CLEAR.
// A READ parks the server in SEND until the response is taken; other commands never stall.
module regfile_msg_server #(
  parameter int unsigned NUM_REGS  = 2,
  parameter int unsigned DATA_W    = 32,
  parameter bit          ZERO_REG0 = 1'b0
) (
  input logic                 clk,
  input logic                 rst,
  regfile_msg_server_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpAdd   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [DATA_W-1:0] rd_val;

  // Read mux by address match: out-of-range addresses match nothing and read 0.
  always_comb begin
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.m_in_addr == ADDR_W'(i) && !(ZERO_REG0 && i == 0)) begin
        rd_val = regs_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    resp_d  = resp_q;
    unique case (state_q)
      StIdle: begin
        if (bus.m_in_sync) begin
          unique case (bus.m_in_op)
            OpWrite, OpAdd: begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (bus.m_in_addr == ADDR_W'(i) && !(ZERO_REG0 && i == 0)) begin
                  regs_d[i] = (bus.m_in_op == OpAdd) ? regs_q[i] + bus.m_in_data
                                                     : bus.m_in_data;
                end
              end
            end
            OpClear: begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
              end
            end
            OpRead: begin
              resp_d  = rd_val;
              state_d = StSend;
            end
            default: ;
          endcase
        end
      end
      StSend: begin
        if (bus.m_out_sync) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      resp_q  <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      resp_q  <= resp_d;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign bus.m_in_notify  = (state_q == StIdle);
  assign bus.m_out_notify = (state_q == StSend);
  assign bus.m_out_data   = resp_q;
endmodule

// File: tb/tb_regfile_msg_server.sv
module tb_regfile_msg_server;
  localparam logic [1:0] WR = 2'b00, RD = 2'b01, AD = 2'b10, CL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Two instances driven with identical commands: A has 3 regs (addr 3 out of range),
  // B has 4 regs with register 0 hardwired to zero.
  regfile_msg_server_if #(.NUM_REGS(3), .DATA_W(8)) if_a ();
  regfile_msg_server_if #(.NUM_REGS(4), .DATA_W(8)) if_b ();

  regfile_msg_server #(.NUM_REGS(3), .DATA_W(8), .ZERO_REG0(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );
  regfile_msg_server #(.NUM_REGS(4), .DATA_W(8), .ZERO_REG0(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain arrays indexed by instance.
  int unsigned nregs [2] = '{3, 4};
  bit          zero0 [2] = '{1'b0, 1'b1};
  logic [7:0]  mdl [2][4];

  function automatic logic [7:0] mdl_rd(input int k, input int unsigned addr);
    if (addr >= nregs[k]) return 8'h00;
    if (zero0[k] && addr == 0) return 8'h00;
    return mdl[k][addr];
  endfunction

  function automatic void mdl_apply(input logic [1:0] op, input int unsigned addr,
                                    input logic [7:0] data);
    for (int k = 0; k < 2; k++) begin
      if (op == CL) begin
        for (int i = 0; i < 4; i++) mdl[k][i] = 8'h00;
      end else if ((op == WR || op == AD) && addr < nregs[k] && !(zero0[k] && addr == 0)) begin
        mdl[k][addr] = (op == AD) ? 8'((int'(mdl[k][addr]) + int'(data)) % 256) : data;
      end
    end
  endfunction

  task automatic check(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[%s] observed=%h expected=%h", tag, (k == 0) ? "a" : "b", obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic in_n, input logic out_n);
    check({tag, "_in_notify"}, 0, 32'(if_a.m_in_notify), 32'(in_n));
    check({tag, "_out_notify"}, 0, 32'(if_a.m_out_notify), 32'(out_n));
    check({tag, "_in_notify"}, 1, 32'(if_b.m_in_notify), 32'(in_n));
    check({tag, "_out_notify"}, 1, 32'(if_b.m_out_notify), 32'(out_n));
  endtask

  task automatic drv_in(input logic sync, input logic [1:0] op, input logic [1:0] addr,
                        input logic [7:0] data);
    if_a.m_in_sync = sync; if_a.m_in_op = op; if_a.m_in_addr = addr; if_a.m_in_data = data;
    if_b.m_in_sync = sync; if_b.m_in_op = op; if_b.m_in_addr = addr; if_b.m_in_data = data;
  endtask

  task automatic drv_out(input logic sync);
    if_a.m_out_sync = sync;
    if_b.m_out_sync = sync;
  endtask

  // One full command; a READ is held for `stall` cycles before its response is taken.
  task automatic cmd(input logic [1:0] op, input logic [1:0] addr, input logic [7:0] data,
                     input int stall);
    logic [7:0] exp [2];
    @(negedge clk);
    check_both("pre_cmd", 1'b1, 1'b0);
    drv_in(1'b1, op, addr, data);
    drv_out(1'($urandom_range(0, 1)));  // must be ignored while idle
    for (int k = 0; k < 2; k++) exp[k] = mdl_rd(k, int'(addr));
    @(posedge clk);
    #1;
    drv_in(1'b0, 2'b00, 2'b00, 8'h00);
    drv_out(1'b0);
    mdl_apply(op, int'(addr), data);
    if (op == RD) begin
      check_both("rd_accept", 1'b0, 1'b1);
      check("rd_data", 0, 32'(if_a.m_out_data), 32'(exp[0]));
      check("rd_data", 1, 32'(if_b.m_out_data), 32'(exp[1]));
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check_both("rd_stall", 1'b0, 1'b1);
        check("rd_hold", 0, 32'(if_a.m_out_data), 32'(exp[0]));
        check("rd_hold", 1, 32'(if_b.m_out_data), 32'(exp[1]));
        // Commands offered during SEND must be ignored.
        drv_in(1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 8'($urandom));
      end
      @(negedge clk);
      drv_in(1'b0, 2'b00, 2'b00, 8'h00);
      drv_out(1'b1);
      @(posedge clk);
      #1;
      drv_out(1'b0);
      check_both("rd_done", 1'b1, 1'b0);
    end else begin
      check_both("no_stall", 1'b1, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) for (int i = 0; i < 4; i++) mdl[k][i] = 8'h00;
    drv_in(1'b0, 2'b00, 2'b00, 8'h00);
    drv_out(1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_both("reset", 1'b1, 1'b0);
    check("reset_data", 0, 32'(if_a.m_out_data), 32'h0);
    check("reset_data", 1, 32'(if_b.m_out_data), 32'h0);
    rst = 1'b1;

    cmd(RD, 2'd1, 8'h00, 0);

    // Wrap on add.
    cmd(WR, 2'd2, 8'h7F, 0);
    cmd(AD, 2'd2, 8'h90, 0);
    cmd(RD, 2'd2, 8'h00, 1);

    // Addr 3: out of range for A, valid for B; long stall with ignored pulses.
    cmd(WR, 2'd3, 8'h55, 0);
    cmd(RD, 2'd3, 8'h00, 5);
    for (int a = 0; a < 3; a++) cmd(RD, 2'(a), 8'h00, 0);

    // Register 0 behaviour and CLEAR.
    cmd(WR, 2'd0, 8'hAA, 0);
    cmd(AD, 2'd0, 8'h01, 0);
    cmd(RD, 2'd0, 8'h00, 0);
    cmd(WR, 2'd1, 8'h05, 0);
    cmd(CL, 2'd2, 8'h33, 0);
    cmd(RD, 2'd1, 8'h00, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      cmd(2'($urandom), 2'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
    end

    // Reset while a response is pending.
    cmd(WR, 2'd1, 8'h3C, 0);
    @(negedge clk);
    drv_in(1'b1, RD, 2'd1, 8'h00);
    @(posedge clk);
    #1;
    drv_in(1'b0, 2'b00, 2'b00, 8'h00);
    check_both("pre_rst_send", 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_both("rst_in_send", 1'b1, 1'b0);
    check("rst_data", 0, 32'(if_a.m_out_data), 32'h0);
    check("rst_data", 1, 32'(if_b.m_out_data), 32'h0);
    mdl_apply(CL, 0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 4; a++) cmd(RD, 2'(a), 8'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_msg_server.md
Name: regfile_msg_server

Overview:
- Parametrised register-file server with blocking message ports, sitting between an abstract master and its register storage.
- Replaces the fixed 2-entry integer array block with configurable depth and data width.
- Adds an opcode-driven command channel (write / read / add / clear) and a response channel for reads.
- Both channels use the codebase's sync/notify blocking handshake.

Parameters:
- NUM_REGS, 2, number of registers (>=2, need not be a power of two).
- DATA_W, 32, register and data width in bits.
- ZERO_REG0, 0, when 1 register 0 always reads 0 and ignores writes/adds.
- ADDR_W, $clog2(NUM_REGS), derived localparam, not overridable.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  reset, asynchronous assertion, active-low (0 = reset).
- m_in_op  input  2  command opcode: 00 WRITE, 01 READ, 10 ADD, 11 CLEAR.
- m_in_addr  input  ADDR_W  target register index.
- m_in_data  input  DATA_W  write/add operand.
- m_in_sync  input  1  master has a valid command.
- m_in_notify  output  1  block ready to accept a command.
- m_out_data  output  DATA_W  read response value.
- m_out_sync  input  1  consumer ready to take the response.
- m_out_notify  output  1  response valid.

Behaviour:
- Handshake: a transfer occurs on a rising edge where sync and notify of the same channel are both 1. Command fields are sampled only on an m_in transfer edge.
- States: IDLE and SEND.
- Reset (rst=0, asynchronous):
  - all registers 0, state IDLE, m_in_notify=1, m_out_notify=0, m_out_data=0.
  - Any pending response is dropped.
- IDLE: m_in_notify=1, m_out_notify=0. On an m_in transfer:
  - WRITE: reg[addr] <= data. Stay IDLE.
  - ADD: reg[addr] <= reg[addr] + data, modulo 2^DATA_W (carry discarded). Stay IDLE.
  - CLEAR: all registers <= 0. Addr and data ignored. Stay IDLE.
  - READ: m_out_data <= reg[addr] (value before this edge). Go to SEND.
- SEND: m_in_notify=0, m_out_notify=1, m_out_data held stable.
  - On an m_out transfer: go to IDLE, m_in_notify=1 and m_out_notify=0 from the next cycle.
- Latency and throughput:
  - WRITE/ADD/CLEAR take effect at the transfer edge, one command per cycle back-to-back.
  - A READ transfer at edge t gives m_out_notify=1 after edge t.
  - The earliest next command is the edge after the m_out transfer, so minimum READ throughput is 1 per 2 cycles.
- m_in_sync is ignored while in SEND. m_out_sync is ignored while in IDLE.
- Out-of-range addr (>= NUM_REGS): WRITE/ADD have no effect; READ returns 0 and still performs the full handshake.
- ZERO_REG0=1: addr 0 READ returns 0; WRITE/ADD to addr 0 are ignored.
- Reset asserted mid-SEND: the response is lost and the block returns to IDLE with m_in_notify=1.

Test Plan:
- Reset, then release with all syncs low -> m_in_notify=1, m_out_notify=0; READ addr 1 returns 0.
- NUM_REGS=4, DATA_W=8: WRITE r2=0x7F, then ADD r2 += 0x90, then READ r2 -> response 0x0F (wrap); m_out_notify rises one cycle after the READ transfer.
- READ r3 while holding m_out_sync=0 for 5 cycles -> m_out_notify and m_out_data stay stable, m_in_notify=0, and m_in_sync pulses are ignored; raise m_out_sync -> back to IDLE next cycle.
- NUM_REGS=3: WRITE addr 3=0x55, then READ addr 3 -> response 0; contents of r0..r2 unchanged.
- ZERO_REG0=1: WRITE r0=0xAA, ADD r0+=1, then READ r0 -> 0. WRITE r1=5, CLEAR, then READ r1 -> 0.
- Assert rst while in SEND -> m_out_notify drops immediately; all registers read back 0 after release.
